// File: rtl/mux_2_input_pkg.sv
// Shared defaults and helpers for the two-input steering mux.
package mux_2_input_pkg;

    localparam int unsigned DEF_WIDTH = 1;
    localparam int unsigned DEF_CNT_W = 8;

    // A select "change" is any edge where the live select differs from its registered copy.
    function automatic logic sel_changed(input logic sel_now, input logic sel_prev);
        return sel_now != sel_prev;
    endfunction

endpackage

// File: rtl/mux_2_input_sat_counter.sv
// Saturating up-counter: counts inc pulses and holds at all-ones.
module mux_2_input_sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (inc && !sat) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign sat   = &count_q;

endmodule

// File: rtl/mux_2_input.sv
// Two-input WIDTH-bit selector with a registered shadow copy and select-activity counter.
module mux_2_input
    import mux_2_input_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_q,
    output logic [CNT_W-1:0] sel_changes,
    output logic             sel_changes_sat
);

    logic [WIDTH-1:0] out_d;
    logic             sel_d;
    logic             sel_inc;

    // Conditional operator gives the per-bit merge when sel is unknown.
    assign out = sel ? b : a;

    always_comb begin
        out_d   = out;
        sel_d   = sel;
        sel_inc = sel_changed(sel, sel_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            sel_q <= 1'b0;
        end else begin
            out_q <= out_d;
            sel_q <= sel_d;
        end
    end

    mux_2_input_sat_counter #(
        .CNT_W (CNT_W)
    ) u_sel_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sel_inc),
        .count (sel_changes),
        .sat   (sel_changes_sat)
    );

endmodule

// File: tb/tb_mux_2_input.sv
// Directed bench: 1-bit, 8-bit and 2-bit-counter instances of mux_2_input.
module tb_mux_2_input;

    logic clk;
    logic clk_en;
    logic rst_n;

    // 1-bit default instance
    logic       a1, b1, sel1;
    logic       out1, out_q1, sel_q1, sat1;
    logic [7:0] cnt1;

    // 8-bit data instance
    logic [7:0] a8, b8, out8, out_q8;
    logic       sel8, sel_q8, sat8;
    logic [7:0] cnt8;

    // 2-bit counter instance
    logic       as, bs, sels, outs, out_qs, sel_qs, sats;
    logic [1:0] cnts;

    int n_checks;
    int n_errors;

    mux_2_input #(.WIDTH(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(sel1),
        .out(out1), .out_q(out_q1), .sel_q(sel_q1),
        .sel_changes(cnt1), .sel_changes_sat(sat1)
    );

    mux_2_input #(.WIDTH(8), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sel(sel8),
        .out(out8), .out_q(out_q8), .sel_q(sel_q8),
        .sel_changes(cnt8), .sel_changes_sat(sat8)
    );

    mux_2_input #(.WIDTH(1), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .a(as), .b(bs), .sel(sels),
        .out(outs), .out_q(out_qs), .sel_q(sel_qs),
        .sel_changes(cnts), .sel_changes_sat(sats)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clk_en = 1'b0;
        rst_n  = 1'b0;
        a1 = 0; b1 = 0; sel1 = 0;
        a8 = 8'h00; b8 = 8'h00; sel8 = 0;
        as = 0; bs = 0; sels = 0;
        #2;

        // Reset state before any clock
        check("rst_out_q",   32'(out_q1), 32'h0);
        check("rst_sel_q",   32'(sel_q1), 32'h0);
        check("rst_cnt",     32'(cnt1),   32'h0);
        check("rst_sat",     32'(sat1),   32'h0);

        // Combinational select, no clock running
        rst_n = 1'b1;
        a1 = 0; b1 = 0; sel1 = 0; #1; check("comb_00_s0", 32'(out1), 32'h0);
        a1 = 1; b1 = 0; sel1 = 1; #1; check("comb_10_s1", 32'(out1), 32'h0);
        a1 = 1; b1 = 0; sel1 = 0; #1; check("comb_10_s0", 32'(out1), 32'h1);
        a1 = 0; b1 = 1; sel1 = 1; #1; check("comb_01_s1", 32'(out1), 32'h1);

        a8 = 8'hA5; b8 = 8'h3C;
        sel8 = 0; #1; check("w8_sel0", 32'(out8), 32'hA5);
        sel8 = 1; #1; check("w8_sel1", 32'(out8), 32'h3C);

        // Restart from reset with sel low, then run the clock
        rst_n = 1'b0;
        sel1 = 0; a1 = 0; b1 = 0;
        #1;
        rst_n  = 1'b1;
        clk_en = 1'b1;
        tick();
        check("w8_out_q", 32'(out_q8), 32'h3C);
        check("w8_sel_q", 32'(sel_q8), 32'h1);
        check("cnt_idle", 32'(cnt1), 32'h0);

        // Toggle every cycle for 5 cycles
        for (int i = 0; i < 5; i++) begin
            sel1 = ~sel1;
            tick();
        end
        check("toggle5_cnt", 32'(cnt1), 32'h5);
        check("toggle5_sel_q", 32'(sel_q1), 32'h1);

        // Hold 3 cycles
        for (int i = 0; i < 3; i++) tick();
        check("hold3_cnt", 32'(cnt1), 32'h5);

        // Double toggle between edges: no increment
        sel1 = 0; #1; sel1 = 1;
        tick();
        check("dbl_toggle_cnt", 32'(cnt1), 32'h5);

        // Saturation with CNT_W=2
        for (int i = 0; i < 2; i++) begin
            sels = ~sels;
            tick();
        end
        check("sat2_cnt", 32'(cnts), 32'h2);
        check("sat2_flag", 32'(sats), 32'h0);
        for (int i = 0; i < 4; i++) begin
            sels = ~sels;
            tick();
        end
        check("sat6_cnt", 32'(cnts), 32'h3);
        check("sat6_flag", 32'(sats), 32'h1);
        for (int i = 0; i < 2; i++) begin
            sels = ~sels;
            tick();
        end
        check("sat_held_cnt", 32'(cnts), 32'h3);

        // Mid-operation asynchronous reset
        a1 = 1; b1 = 1; sel1 = 1;
        tick();
        check("pre_rst_out_q", 32'(out_q1), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_q", 32'(out_q1), 32'h0);
        check("mid_rst_sel_q", 32'(sel_q1), 32'h0);
        check("mid_rst_cnt",   32'(cnt1),   32'h0);
        check("mid_rst_sat_cnt", 32'(cnts), 32'h0);
        check("mid_rst_sat_flag", 32'(sats), 32'h0);
        check("mid_rst_out",   32'(out1),   32'h1);

        // Reset held across an edge keeps registers cleared
        tick();
        check("rst_hold_sel_q", 32'(sel_q1), 32'h0);

        // First edge after release: sel=1 counts as a change
        #1;
        rst_n = 1'b1;
        tick();
        check("post_rst_cnt",   32'(cnt1),   32'h1);
        check("post_rst_sel_q", 32'(sel_q1), 32'h1);
        check("post_rst_out_q", 32'(out_q1), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
